// File: rtl/exers.sv
// exers: integer execution reservation station with writeback wakeup and lowest-index select.
// Define EXERS_PERF_EN to add the full-stall and issue performance counters.
module exers #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rename_exers_write,
    input  logic [4:0]  rename_op,
    input  logic [7:0]  rename_robid,
    input  logic [5:0]  rename_rd,
    input  logic        rename_op1ready,
    input  logic [31:0] rename_op1,
    input  logic        rename_op2ready,
    input  logic [31:0] rename_op2,
    input  logic [31:0] rename_imm,
    output logic        exers_stall,
    input  logic        wb_valid,
    input  logic [7:0]  wb_robid,
    input  logic [31:0] wb_result,
    output logic        exers_issue_valid,
    output logic [4:0]  exers_issue_op,
    output logic [7:0]  exers_issue_robid,
    output logic [5:0]  exers_issue_rd,
    output logic [31:0] exers_issue_op1,
    output logic [31:0] exers_issue_op2,
    output logic [31:0] exers_issue_imm,
    input  logic        alu_stall,
    input  logic        rob_flush
`ifdef EXERS_PERF_EN
    ,
    output logic [31:0] exers_perf_full,
    output logic [31:0] exers_perf_issued
`endif
);
    logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d, elig;
    logic [4:0]       op_q    [DEPTH];
    logic [4:0]       op_d    [DEPTH];
    logic [7:0]       robid_q [DEPTH];
    logic [7:0]       robid_d [DEPTH];
    logic [5:0]       rd_q    [DEPTH];
    logic [5:0]       rd_d    [DEPTH];
    logic [31:0]      val1_q  [DEPTH];
    logic [31:0]      val1_d  [DEPTH];
    logic [31:0]      val2_q  [DEPTH];
    logic [31:0]      val2_d  [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      imm_d   [DEPTH];
    logic [IDX_W-1:0] sel, free_idx;
    logic             wr_acc, fire, byp1, byp2;

    assign elig              = valid_q & rdy1_q & rdy2_q;
    assign exers_stall       = &valid_q;
    assign exers_issue_valid = (|elig) & ~rob_flush;
    assign fire              = exers_issue_valid & ~alu_stall;
    assign wr_acc            = rename_exers_write & ~exers_stall & ~rob_flush;
    assign byp1              = wb_valid & ~rename_op1ready & (wb_robid == rename_op1[7:0]);
    assign byp2              = wb_valid & ~rename_op2ready & (wb_robid == rename_op2[7:0]);

    assign exers_issue_op    = exers_issue_valid ? op_q[sel]    : '0;
    assign exers_issue_robid = exers_issue_valid ? robid_q[sel] : '0;
    assign exers_issue_rd    = exers_issue_valid ? rd_q[sel]    : '0;
    assign exers_issue_op1   = exers_issue_valid ? val1_q[sel]  : '0;
    assign exers_issue_op2   = exers_issue_valid ? val2_q[sel]  : '0;
    assign exers_issue_imm   = exers_issue_valid ? imm_q[sel]   : '0;

    // Descending scan so the lowest index wins for both select and allocate.
    always_comb begin
        sel      = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) sel = IDX_W'(i);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        op_d    = op_q;
        robid_d = robid_q;
        rd_d    = rd_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        imm_d   = imm_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && valid_q[i] && !rdy1_q[i] && wb_robid == val1_q[i][7:0]) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = wb_result;
            end
            if (wb_valid && valid_q[i] && !rdy2_q[i] && wb_robid == val2_q[i][7:0]) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = wb_result;
            end
        end
        if (fire) valid_d[sel] = 1'b0;
        if (wr_acc) begin
            valid_d[free_idx] = 1'b1;
            op_d[free_idx]    = rename_op;
            robid_d[free_idx] = rename_robid;
            rd_d[free_idx]    = rename_rd;
            imm_d[free_idx]   = rename_imm;
            rdy1_d[free_idx]  = rename_op1ready | byp1;
            val1_d[free_idx]  = byp1 ? wb_result : rename_op1;
            rdy2_d[free_idx]  = rename_op2ready | byp2;
            val2_d[free_idx]  = byp2 ? wb_result : rename_op2;
        end
        if (rob_flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        rdy1_q  <= rdy1_d;
        rdy2_q  <= rdy2_d;
        op_q    <= op_d;
        robid_q <= robid_d;
        rd_q    <= rd_d;
        val1_q  <= val1_d;
        val2_q  <= val2_d;
        imm_q   <= imm_d;
    end

`ifdef EXERS_PERF_EN
    logic [31:0] perf_full_q, perf_full_d, perf_issued_q, perf_issued_d;
    always_comb begin
        perf_full_d   = perf_full_q + 32'(exers_stall & rename_exers_write);
        perf_issued_d = perf_issued_q + 32'(fire);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_q   <= '0;
            perf_issued_q <= '0;
        end else begin
            perf_full_q   <= perf_full_d;
            perf_issued_q <= perf_issued_d;
        end
    end
    assign exers_perf_full   = perf_full_q;
    assign exers_perf_issued = perf_issued_q;
`endif
endmodule
